instr_fetch_unit: RTL and testbench

//  Instruction-supply end of the control-FSM handshake: owns PC and IR, answers write_ir requests by

---
 rtl/cson_fetch_pkg.sv | 15 +
 rtl/instr_fetch_unit_if.sv | 10 +
 rtl/ifu_prefetch_buf.sv | 35 +++
 rtl/instr_fetch_unit.sv | 126 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/cson_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package cson_fetch_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, VALID, DRAIN} fetch_state_e;

    localparam logic [1:0]  PC_S_INC = 2'b00;
    localparam logic [1:0]  PC_S_B   = 2'b01;
    localparam logic [1:0]  PC_S_F   = 2'b10;
    localparam logic [31:0] IR_RESET = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read port: req/addr held until ack returns rdata.
interface instr_fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, addr, input ack, rdata);
    modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/ifu_prefetch_buf.sv
// One-entry prefetch buffer (data + address + valid); only built with IFU_PREFETCH_EN.
`ifdef IFU_PREFETCH_EN
module ifu_prefetch_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        fill_i,
    input  logic        clear_i,
    input  logic [31:0] data_i,
    input  logic [31:0] addr_i,
    output logic        valid_o,
    output logic [31:0] data_o,
    output logic [31:0] addr_o
);
    logic        valid_q;
    logic [31:0] data_q, addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (fill_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            addr_q  <= addr_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign addr_o  = addr_q;
endmodule
`endif

// File: rtl/instr_fetch_unit.sv
// PC/IR owner: answers write_ir with a memory fetch and a one-cycle W_IR_valid pulse, applies redirects.
// Optional IFU_PREFETCH_EN adds a one-entry prefetch buffer for 1-cycle delivery.
module instr_fetch_unit
    import cson_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      write_ir,
    input  logic                      write_pc,
    input  logic [1:0]                pc_s,
    input  logic [31:0]               B_data,
    input  logic [31:0]               F_data,
    instr_fetch_unit_if.master        imem,
    output logic [31:0]               IR,
    output logic                      W_IR_valid,
    output logic [31:0]               PC
);
    fetch_state_e state_q;
    logic [31:0]  pc_q, ir_q, addr_q;
    logic         valid_q, req_q, pf_q, arm_q;
    logic         redirect, buf_hit;
    logic [31:0]  target, pc_inc, buf_data;

    assign redirect = write_pc && (pc_s == PC_S_B || pc_s == PC_S_F);
    assign target   = word_align((pc_s == PC_S_B) ? B_data : F_data);
    assign pc_inc   = pc_q + 32'(PC_STEP);

`ifdef IFU_PREFETCH_EN
    localparam bit PF_EN = 1'b1;
    logic        buf_valid, buf_fill, buf_clear;
    logic [31:0] buf_addr;

    // A prefetch that the FSM is already asking for is delivered directly instead of buffered.
    assign buf_hit   = buf_valid && (buf_addr == pc_q);
    assign buf_fill  = (state_q == FETCH) && pf_q && imem.ack && !redirect && !write_ir;
    assign buf_clear = redirect || ((state_q == IDLE) && write_ir && buf_hit);

    ifu_prefetch_buf u_buf (
        .clk     (clk),
        .rst     (rst),
        .fill_i  (buf_fill),
        .clear_i (buf_clear),
        .data_i  (imem.rdata),
        .addr_i  (addr_q),
        .valid_o (buf_valid),
        .data_o  (buf_data),
        .addr_o  (buf_addr)
    );
`else
    localparam bit PF_EN = 1'b0;
    assign buf_hit  = 1'b0;
    assign buf_data = IR_RESET;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= IR_RESET;
            addr_q  <= RESET_PC;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
            pf_q    <= 1'b0;
            arm_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (redirect) pc_q <= target;
            case (state_q)
                IDLE: begin
                    if (redirect) begin
                        state_q <= IDLE;
                    end else if (write_ir && buf_hit) begin
                        ir_q    <= buf_data;
                        pc_q    <= pc_inc;
                        valid_q <= 1'b1;
                        state_q <= VALID;
                    end else if (write_ir || (PF_EN && arm_q && !buf_hit)) begin
                        req_q   <= 1'b1;
                        addr_q  <= pc_q;
                        pf_q    <= !write_ir;
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    // A redirect obsoletes the outstanding read; drain it if ack hasn't come yet.
                    if (redirect) begin
                        if (imem.ack) begin
                            req_q   <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            state_q <= DRAIN;
                        end
                    end else if (imem.ack) begin
                        req_q <= 1'b0;
                        if (pf_q && !write_ir) begin
                            state_q <= IDLE;
                        end else begin
                            ir_q    <= imem.rdata;
                            pc_q    <= pc_inc;
                            valid_q <= 1'b1;
                            arm_q   <= 1'b1;
                            state_q <= VALID;
                        end
                    end
                end
                VALID: state_q <= IDLE;
                DRAIN: begin
                    if (imem.ack) begin
                        req_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign imem.req   = req_q;
    assign imem.addr  = addr_q;
    assign IR         = ir_q;
    assign W_IR_valid = valid_q;
    assign PC         = pc_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed vector table, hand sequences, random vs. reference model.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        write_ir = 1'b0, write_pc = 1'b0;
    logic [1:0]  pc_s = 2'b00;
    logic [31:0] B_data = '0, F_data = '0;
    logic [31:0] IR, PC;
    logic        W_IR_valid;
    int          n_chk = 0, n_fail = 0;

    instr_fetch_unit_if imem_if();

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .write_ir   (write_ir),
        .write_pc   (write_pc),
        .pc_s       (pc_s),
        .B_data     (B_data),
        .F_data     (F_data),
        .imem       (imem_if),
        .IR         (IR),
        .W_IR_valid (W_IR_valid),
        .PC         (PC)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wir, wpc;
        logic [1:0]  pcs;
        logic [31:0] b, f;
        logic        ack;
        logic [31:0] rd;
        logic        ev, ereq;
        logic [31:0] eir, epc, eaddr;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(input logic wir, input logic wpc, input logic [1:0] pcs,
                                input logic [31:0] b, input logic [31:0] f, input logic ack,
                                input logic [31:0] rd, input logic ev, input logic ereq,
                                input logic [31:0] eir, input logic [31:0] epc, input logic [31:0] eaddr);
        vec_t v;
        v.wir = wir; v.wpc = wpc; v.pcs = pcs; v.b = b; v.f = f; v.ack = ack; v.rd = rd;
        v.ev = ev; v.ereq = ereq; v.eir = eir; v.epc = epc; v.eaddr = eaddr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic ereq,
                           input logic [31:0] eir, input logic [31:0] epc, input logic [31:0] eaddr);
        chk({tag, ".valid"}, 32'(W_IR_valid), 32'(ev));
        chk({tag, ".req"},   32'(imem_if.req), 32'(ereq));
        chk({tag, ".IR"},    IR, eir);
        chk({tag, ".PC"},    PC, epc);
        chk({tag, ".addr"},  imem_if.addr, eaddr);
    endtask

    // reference model state (transaction view: outstanding read, whether it is stale, pulse)
    logic [31:0] m_pc, m_ir, m_addr, tgt;
    logic        m_busy, m_stale, m_pulse, redir, pulse_n;

    initial begin
        imem_if.ack   = 1'b0;
        imem_if.rdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_all("reset", 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);

        //             wir  wpc  pcs    B             F             ack  rdata         v    req  IR            PC            addr
        tbl[0]  = mk(1'b1,1'b0,2'b00,32'h0,        32'h0,        1'b0,32'h0,        1'b0,1'b1,32'h0,        32'h0,        32'h0);
        tbl[1]  = mk(1'b1,1'b0,2'b00,32'h0,        32'h0,        1'b1,32'hE2801001, 1'b1,1'b0,32'hE2801001, 32'h4,        32'h0);
        tbl[2]  = mk(1'b1,1'b0,2'b00,32'h0,        32'h0,        1'b0,32'h0,        1'b0,1'b0,32'hE2801001, 32'h4,        32'h0);
        tbl[3]  = mk(1'b0,1'b1,2'b01,32'h102,      32'h0,        1'b0,32'h0,        1'b0,1'b0,32'hE2801001, 32'h100,      32'h0);
        tbl[4]  = mk(1'b1,1'b0,2'b00,32'h0,        32'h0,        1'b0,32'h0,        1'b0,1'b1,32'hE2801001, 32'h100,      32'h100);
        tbl[5]  = mk(1'b1,1'b0,2'b00,32'h0,        32'h0,        1'b0,32'h0,        1'b0,1'b1,32'hE2801001, 32'h100,      32'h100);
        tbl[6]  = mk(1'b1,1'b1,2'b10,32'h0,        32'h40,       1'b0,32'h0,        1'b0,1'b1,32'hE2801001, 32'h40,       32'h100);
        tbl[7]  = mk(1'b1,1'b0,2'b00,32'h0,        32'h0,        1'b0,32'h0,        1'b0,1'b1,32'hE2801001, 32'h40,       32'h100);
        tbl[8]  = mk(1'b1,1'b0,2'b00,32'h0,        32'h0,        1'b1,32'hDEADBEEF, 1'b0,1'b0,32'hE2801001, 32'h40,       32'h100);
        tbl[9]  = mk(1'b1,1'b0,2'b00,32'h0,        32'h0,        1'b0,32'h0,        1'b0,1'b1,32'hE2801001, 32'h40,       32'h40);
        tbl[10] = mk(1'b1,1'b1,2'b10,32'h0,        32'hFFFFFFFF, 1'b1,32'h12345678, 1'b0,1'b0,32'hE2801001, 32'hFFFFFFFC, 32'h40);
        tbl[11] = mk(1'b1,1'b0,2'b00,32'h0,        32'h0,        1'b0,32'h0,        1'b0,1'b1,32'hE2801001, 32'hFFFFFFFC, 32'hFFFFFFFC);
        tbl[12] = mk(1'b1,1'b0,2'b00,32'h0,        32'h0,        1'b1,32'hAABBCCDD, 1'b1,1'b0,32'hAABBCCDD, 32'h0,        32'hFFFFFFFC);
        tbl[13] = mk(1'b0,1'b1,2'b11,32'h500,      32'h600,      1'b0,32'h0,        1'b0,1'b0,32'hAABBCCDD, 32'h0,        32'hFFFFFFFC);
        tbl[14] = mk(1'b0,1'b1,2'b00,32'h700,      32'h800,      1'b0,32'h0,        1'b0,1'b0,32'hAABBCCDD, 32'h0,        32'hFFFFFFFC);
        tbl[15] = mk(1'b0,1'b1,2'b01,32'h2000,     32'h0,        1'b0,32'h0,        1'b0,1'b0,32'hAABBCCDD, 32'h2000,     32'hFFFFFFFC);
        tbl[16] = mk(1'b1,1'b0,2'b00,32'h0,        32'h0,        1'b0,32'h0,        1'b0,1'b1,32'hAABBCCDD, 32'h2000,     32'h2000);
        tbl[17] = mk(1'b1,1'b0,2'b00,32'h0,        32'h0,        1'b1,32'h11112222, 1'b1,1'b0,32'h11112222, 32'h2004,     32'h2000);
        tbl[18] = mk(1'b0,1'b1,2'b01,32'h3003,     32'h0,        1'b0,32'h0,        1'b0,1'b0,32'h11112222, 32'h3000,     32'h2000);

        for (int i = 0; i < 19; i++) begin
            write_ir = tbl[i].wir; write_pc = tbl[i].wpc; pc_s = tbl[i].pcs;
            B_data = tbl[i].b; F_data = tbl[i].f;
            imem_if.ack = tbl[i].ack; imem_if.rdata = tbl[i].rd;
            @(posedge clk); #1;
            chk_all($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ereq, tbl[i].eir, tbl[i].epc, tbl[i].eaddr);
        end

        // delayed ack: address stable over the wait, single pulse right after ack
        write_ir = 1'b1; write_pc = 1'b0; pc_s = 2'b00; imem_if.ack = 1'b0;
        @(posedge clk); #1;
        chk_all("slow.issue", 1'b0, 1'b1, 32'h11112222, 32'h3000, 32'h3000);
        for (int w = 0; w < 3; w++) begin
            @(posedge clk); #1;
            chk_all($sformatf("slow.wait%0d", w), 1'b0, 1'b1, 32'h11112222, 32'h3000, 32'h3000);
        end
        imem_if.ack = 1'b1; imem_if.rdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        chk_all("slow.ack", 1'b1, 1'b0, 32'hCAFEF00D, 32'h3004, 32'h3000);
        imem_if.ack = 1'b0; write_ir = 1'b0;
        @(posedge clk); #1;
        chk("slow.pulse_end", 32'(W_IR_valid), 32'h0);
        @(posedge clk); #1;
        chk("slow.no_repeat", 32'(W_IR_valid), 32'h0);

        // asynchronous reset in the middle of a fetch
        write_ir = 1'b1;
        @(posedge clk); #1;
        chk("rst.pre_req", 32'(imem_if.req), 32'h1);
        #2 rst = 1'b1;
        #1 chk_all("rst.async", 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        write_ir = 1'b0;
        @(posedge clk); #1 rst = 1'b0;

        m_pc = '0; m_ir = '0; m_addr = '0; m_busy = 1'b0; m_stale = 1'b0; m_pulse = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            write_ir = ($urandom_range(0, 9) < 7);
            write_pc = ($urandom_range(0, 9) == 0);
            pc_s     = 2'($urandom_range(0, 3));
            B_data   = $urandom;
            F_data   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3))) : $urandom;
            imem_if.ack   = imem_if.req && ($urandom_range(0, 2) == 0);
            imem_if.rdata = $urandom;

            redir   = write_pc && (pc_s == 2'b01 || pc_s == 2'b10);
            tgt     = ((pc_s == 2'b01) ? B_data : F_data) & ~32'h3;
            pulse_n = 1'b0;
            if (m_busy) begin
                if (redir) m_stale = 1'b1;
                if (imem_if.ack) begin
                    m_busy = 1'b0;
                    if (!m_stale) begin
                        m_ir    = imem_if.rdata;
                        m_pc    = m_pc + 32'd4;
                        pulse_n = 1'b1;
                    end
                    m_stale = 1'b0;
                end
            end else if (!m_pulse && !redir && write_ir) begin
                m_busy = 1'b1;
                m_addr = m_pc;
            end
            if (redir) m_pc = tgt;
            m_pulse = pulse_n;

            @(posedge clk); #1;
            chk($sformatf("rnd%0d.valid", c), 32'(W_IR_valid), 32'(m_pulse));
            chk($sformatf("rnd%0d.req", c), 32'(imem_if.req), 32'(m_busy));
            chk($sformatf("rnd%0d.IR", c), IR, m_ir);
            chk($sformatf("rnd%0d.PC", c), PC, m_pc);
            if (m_busy) chk($sformatf("rnd%0d.addr", c), imem_if.addr, m_addr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
